// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that funnels ALU and LSU results, each buffered in its own
// small FIFO, onto one registered common-data-bus broadcast port.
module cdb_arbiter #(
  parameter int ROB_ID_W  = 6,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                rollback_flag,
  input  logic                alu_valid_in,
  output logic                alu_ready_out,
  input  logic [ROB_ID_W-1:0] alu_rob_id_in,
  input  logic [DATA_W-1:0]   alu_result_in,
  input  logic [ADDR_W-1:0]   alu_target_pos_in,
  input  logic                alu_jump_flag_in,
  input  logic                lsu_valid_in,
  output logic                lsu_ready_out,
  input  logic [ROB_ID_W-1:0] lsu_rob_id_in,
  input  logic [DATA_W-1:0]   lsu_result_in,
  output logic                cdb_enable_out,
  output logic [ROB_ID_W-1:0] cdb_rob_id_out,
  output logic [DATA_W-1:0]   cdb_result_out,
  output logic [ADDR_W-1:0]   cdb_target_pos_out,
  output logic                cdb_jump_flag_out,
  output logic                cdb_src_out,
  output logic [15:0]         dbg_conflict_count
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int ENT_W = ROB_ID_W + DATA_W + ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  // Index 0 is the ALU source, index 1 the LSU source (matches cdb_src_out).
  logic [1:0]       in_valid, ready, push, pop, nonempty;
  logic [ENT_W-1:0] in_entry   [2];
  logic [ENT_W-1:0] head_entry [2];

  assign in_valid    = {lsu_valid_in, alu_valid_in};
  assign in_entry[0] = {alu_rob_id_in, alu_result_in, alu_target_pos_in, alu_jump_flag_in};
  assign in_entry[1] = {lsu_rob_id_in, lsu_result_in, {ADDR_W{1'b0}}, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [ENT_W-1:0] mem_q [BUF_DEPTH];
      logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      assign ready[gi]      = rdy_in && !rollback_flag && (cnt_q < DEPTH_C);
      // A rob id of 0 completes the handshake but is never stored.
      assign push[gi]       = in_valid[gi] && ready[gi] &&
                              (in_entry[gi][ENT_W-1 -: ROB_ID_W] != '0);
      assign nonempty[gi]   = (cnt_q != '0);
      assign head_entry[gi] = mem_q[rd_ptr_q];

      always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (rollback_flag) begin
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end else if (rdy_in) begin
          if (push[gi]) wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (pop[gi])  rd_ptr_d = rd_ptr_q + PTR_W'(1);
          case ({push[gi], pop[gi]})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
          endcase
        end
      end

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          rd_ptr_q <= '0;
          wr_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          rd_ptr_q <= rd_ptr_d;
          wr_ptr_q <= wr_ptr_d;
          cnt_q    <= cnt_d;
        end
      end

      always_ff @(posedge clk_in) begin
        if (push[gi]) mem_q[wr_ptr_q] <= in_entry[gi];
      end
    end
  endgenerate

  logic                grant_valid, grant_src;
  logic                last_grant_q, last_grant_d;
  logic                cdb_en_q, cdb_en_d, cdb_jmp_q, cdb_jmp_d, cdb_src_q, cdb_src_d;
  logic [ROB_ID_W-1:0] cdb_rob_q, cdb_rob_d;
  logic [DATA_W-1:0]   cdb_res_q, cdb_res_d;
  logic [ADDR_W-1:0]   cdb_tgt_q, cdb_tgt_d;
  logic [15:0]         conflict_q, conflict_d;

  // Under contention the source that did not win last time gets the bus.
  assign grant_valid = |nonempty;
  assign grant_src   = nonempty[1] && (!nonempty[0] || !last_grant_q);
  assign pop[0]      = grant_valid && !grant_src;
  assign pop[1]      = grant_valid && grant_src;

  always_comb begin
    last_grant_d = last_grant_q;
    cdb_en_d     = cdb_en_q;
    cdb_rob_d    = cdb_rob_q;
    cdb_res_d    = cdb_res_q;
    cdb_tgt_d    = cdb_tgt_q;
    cdb_jmp_d    = cdb_jmp_q;
    cdb_src_d    = cdb_src_q;
    conflict_d   = conflict_q;
    if (rollback_flag) begin
      cdb_en_d     = 1'b0;
      last_grant_d = 1'b1;
    end else if (rdy_in) begin
      cdb_en_d = grant_valid;
      if (grant_valid) begin
        {cdb_rob_d, cdb_res_d, cdb_tgt_d, cdb_jmp_d} = head_entry[grant_src];
        cdb_src_d    = grant_src;
        last_grant_d = grant_src;
      end
      if (&nonempty) conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_grant_q <= 1'b1;
      cdb_en_q     <= 1'b0;
      cdb_rob_q    <= '0;
      cdb_res_q    <= '0;
      cdb_tgt_q    <= '0;
      cdb_jmp_q    <= 1'b0;
      cdb_src_q    <= 1'b0;
      conflict_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      cdb_en_q     <= cdb_en_d;
      cdb_rob_q    <= cdb_rob_d;
      cdb_res_q    <= cdb_res_d;
      cdb_tgt_q    <= cdb_tgt_d;
      cdb_jmp_q    <= cdb_jmp_d;
      cdb_src_q    <= cdb_src_d;
      conflict_q   <= conflict_d;
    end
  end

  assign alu_ready_out      = ready[0];
  assign lsu_ready_out      = ready[1];
  assign cdb_enable_out     = cdb_en_q;
  assign cdb_rob_id_out     = cdb_rob_q;
  assign cdb_result_out     = cdb_res_q;
  assign cdb_target_pos_out = cdb_tgt_q;
  assign cdb_jump_flag_out  = cdb_jmp_q;
  assign cdb_src_out        = cdb_src_q;
  assign dbg_conflict_count = conflict_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, round-robin order, back-pressure,
// rollback flush, stall hold and rob-id-0 filtering.
module tb_cdb_arbiter;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rollback_flag;
  logic        alu_valid_in, alu_ready_out, alu_jump_flag_in;
  logic [5:0]  alu_rob_id_in;
  logic [31:0] alu_result_in, alu_target_pos_in;
  logic        lsu_valid_in, lsu_ready_out;
  logic [5:0]  lsu_rob_id_in;
  logic [31:0] lsu_result_in;
  logic        cdb_enable_out, cdb_jump_flag_out, cdb_src_out;
  logic [5:0]  cdb_rob_id_out;
  logic [31:0] cdb_result_out, cdb_target_pos_out;
  logic [15:0] dbg_conflict_count;

  int n_cmp = 0;
  int n_bad = 0;

  cdb_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rollback_flag(rollback_flag),
    .alu_valid_in(alu_valid_in), .alu_ready_out(alu_ready_out),
    .alu_rob_id_in(alu_rob_id_in), .alu_result_in(alu_result_in),
    .alu_target_pos_in(alu_target_pos_in), .alu_jump_flag_in(alu_jump_flag_in),
    .lsu_valid_in(lsu_valid_in), .lsu_ready_out(lsu_ready_out),
    .lsu_rob_id_in(lsu_rob_id_in), .lsu_result_in(lsu_result_in),
    .cdb_enable_out(cdb_enable_out), .cdb_rob_id_out(cdb_rob_id_out),
    .cdb_result_out(cdb_result_out), .cdb_target_pos_out(cdb_target_pos_out),
    .cdb_jump_flag_out(cdb_jump_flag_out), .cdb_src_out(cdb_src_out),
    .dbg_conflict_count(dbg_conflict_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bcast(input string tag, input logic [5:0] id, input logic src);
    chk({tag, "_en"}, cdb_enable_out, 1);
    chk({tag, "_id"}, cdb_rob_id_out, id);
    chk({tag, "_src"}, cdb_src_out, src);
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rdy_in = 1'b1; rollback_flag = 1'b0;
    alu_valid_in = 1'b0; alu_rob_id_in = '0; alu_result_in = '0;
    alu_target_pos_in = '0; alu_jump_flag_in = 1'b0;
    lsu_valid_in = 1'b0; lsu_rob_id_in = '0; lsu_result_in = '0;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_en", cdb_enable_out, 0);
    chk("rst_id", cdb_rob_id_out, 0);
    chk("rst_res", cdb_result_out, 0);
    chk("rst_tgt", cdb_target_pos_out, 0);
    chk("rst_jmp", cdb_jump_flag_out, 0);
    chk("rst_src", cdb_src_out, 0);
    chk("rst_cnt", dbg_conflict_count, 0);
    chk("rst_alu_rdy", alu_ready_out, 1);
    chk("rst_lsu_rdy", lsu_ready_out, 1);

    // Single ALU entry: two-edge latency, one-cycle pulse, data holds.
    alu_valid_in = 1; alu_rob_id_in = 5; alu_result_in = 32'h11;
    alu_target_pos_in = 32'h100; alu_jump_flag_in = 1;
    tick();
    alu_valid_in = 0;
    chk("lat_e1_en", cdb_enable_out, 0);
    tick();
    bcast("lat_e2", 5, 0);
    chk("lat_res", cdb_result_out, 32'h11);
    chk("lat_tgt", cdb_target_pos_out, 32'h100);
    chk("lat_jmp", cdb_jump_flag_out, 1);
    tick();
    chk("lat_e3_en", cdb_enable_out, 0);
    chk("lat_e3_hold", cdb_rob_id_out, 5);

    do_reset();
    chk("rst2_id", cdb_rob_id_out, 0);
    chk("rst2_tgt", cdb_target_pos_out, 0);

    // Contention: expect 1,3,2,4 and three conflict edges.
    alu_valid_in = 1; alu_rob_id_in = 1; alu_result_in = 32'hA1;
    alu_target_pos_in = 32'hAA; alu_jump_flag_in = 1;
    lsu_valid_in = 1; lsu_rob_id_in = 3; lsu_result_in = 32'hB3;
    tick();
    alu_rob_id_in = 2; alu_result_in = 32'hA2;
    lsu_rob_id_in = 4; lsu_result_in = 32'hB4;
    tick();
    alu_valid_in = 0; lsu_valid_in = 0;
    bcast("con_1", 1, 0);
    tick();
    bcast("con_3", 3, 1);
    chk("con_3_res", cdb_result_out, 32'hB3);
    chk("con_3_tgt", cdb_target_pos_out, 0);
    chk("con_3_jmp", cdb_jump_flag_out, 0);
    tick();
    bcast("con_2", 2, 0);
    chk("con_2_res", cdb_result_out, 32'hA2);
    tick();
    bcast("con_4", 4, 1);
    tick();
    chk("con_end_en", cdb_enable_out, 0);
    chk("con_cnt", dbg_conflict_count, 3);

    // Back-pressure: LSU 7,8,9 against ALU 14,15,16.
    do_reset();
    alu_valid_in = 1; alu_rob_id_in = 14;
    lsu_valid_in = 1; lsu_rob_id_in = 7;
    tick();
    alu_rob_id_in = 15; lsu_rob_id_in = 8;
    chk("bp_e1_lrdy", lsu_ready_out, 1);
    tick();
    bcast("bp_14", 14, 0);
    chk("bp_e2_lrdy", lsu_ready_out, 0);
    alu_rob_id_in = 16; lsu_rob_id_in = 9;
    tick();
    bcast("bp_7", 7, 1);
    chk("bp_e3_lrdy", lsu_ready_out, 1);
    chk("bp_e3_ardy", alu_ready_out, 0);
    alu_valid_in = 0;
    tick();
    bcast("bp_15", 15, 0);
    lsu_valid_in = 0;
    tick();
    bcast("bp_8", 8, 1);
    tick();
    bcast("bp_16", 16, 0);
    tick();
    bcast("bp_9", 9, 1);
    tick();
    chk("bp_end_en", cdb_enable_out, 0);
    chk("bp_cnt", dbg_conflict_count, 5);

    // Rollback flushes queued 10 and refuses 11/12.
    do_reset();
    alu_valid_in = 1; alu_rob_id_in = 10;
    tick();
    alu_rob_id_in = 11; lsu_valid_in = 1; lsu_rob_id_in = 12; rollback_flag = 1;
    #1;
    chk("rb_ardy", alu_ready_out, 0);
    chk("rb_lrdy", lsu_ready_out, 0);
    tick();
    rollback_flag = 0; alu_valid_in = 0; lsu_valid_in = 0;
    chk("rb_e2_en", cdb_enable_out, 0);
    chk("rb_e2_id", cdb_rob_id_out, 0);
    tick();
    chk("rb_e3_en", cdb_enable_out, 0);
    alu_valid_in = 1; alu_rob_id_in = 13;
    tick();
    alu_valid_in = 0;
    chk("rb_e4_en", cdb_enable_out, 0);
    tick();
    bcast("rb_13", 13, 0);
    tick();
    chk("rb_end_en", cdb_enable_out, 0);
    chk("rb_cnt", dbg_conflict_count, 0);

    // Stall holds a pending broadcast and blocks new entries.
    do_reset();
    alu_valid_in = 1; alu_rob_id_in = 20;
    tick();
    alu_rob_id_in = 21;
    tick();
    bcast("st_20", 20, 0);
    alu_valid_in = 0; rdy_in = 0; lsu_valid_in = 1; lsu_rob_id_in = 30;
    #1;
    chk("st_ardy", alu_ready_out, 0);
    chk("st_lrdy", lsu_ready_out, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      bcast("st_hold", 20, 0);
    end
    lsu_valid_in = 0; rdy_in = 1;
    tick();
    bcast("st_21", 21, 0);
    tick();
    chk("st_end_en", cdb_enable_out, 0);

    // Rob id 0 is dropped; id 32 passes through.
    do_reset();
    alu_valid_in = 1; alu_rob_id_in = 0;
    lsu_valid_in = 1; lsu_rob_id_in = 6'h20; lsu_result_in = 32'hDEAD;
    #1;
    chk("id0_ardy", alu_ready_out, 1);
    tick();
    alu_valid_in = 0; lsu_valid_in = 0;
    tick();
    bcast("id32", 6'h20, 1);
    chk("id32_res", cdb_result_out, 32'hDEAD);
    tick();
    chk("id0_en", cdb_enable_out, 0);
    chk("id0_cnt", dbg_conflict_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
